// File: rtl/ram_readback_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ram_readback_checker
// Description : Read-only sweep of a synchronous single-port RAM. Each word is
//               compared against a regenerated 16-bit LFSR fill pattern.
//               Optional macro RAM_CHK_STOP_ON_FIRST_ERR_EN ends the sweep at
//               the first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_readback_checker #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           seed,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data
);

`ifdef RAM_CHK_STOP_ON_FIRST_ERR_EN
    localparam bit C_STOP_ON_ERR = 1'b1;
`else
    localparam bit C_STOP_ON_ERR = 1'b0;
`endif

    localparam logic [15:0]             C_ZERO_SEED_SUB = 16'hACE1;
    localparam logic [ADDR_WIDTH-1:0]   C_LAST_ADDR     = '1;
    // Valid bits of every stage except the one being compared this cycle.
    localparam logic [READ_LATENCY-1:0] C_UP_MASK       =
        READ_LATENCY'((1 << (READ_LATENCY - 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [ADDR_WIDTH:0]     err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]   fea_q, fea_d;
    logic [DATA_WIDTH-1:0]   fed_q, fed_d;

    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [ADDR_WIDTH-1:0]   pipe_addr_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_exp_q  [READ_LATENCY];

    logic                    w_cmp_vld;
    logic                    w_mismatch;
    logic                    w_flush;
    logic                    w_issue;

    function automatic logic [15:0] f_lfsr_next(input logic [15:0] l);
        f_lfsr_next = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign w_cmp_vld  = pipe_vld_q[READ_LATENCY-1];
    assign w_mismatch = w_cmp_vld && (mem_q != pipe_exp_q[READ_LATENCY-1]);
    assign w_flush    = w_mismatch && C_STOP_ON_ERR;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lfsr_d    = lfsr_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        fea_d     = fea_q;
        fed_d     = fed_q;
        w_issue   = 1'b0;

        if (w_mismatch) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) begin
                fea_d = pipe_addr_q[READ_LATENCY-1];
                fed_d = mem_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_READ;
                    addr_d    = '0;
                    lfsr_d    = (seed == 16'h0000) ? C_ZERO_SEED_SUB : seed;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_cnt_d = '0;
                    fea_d     = '0;
                    fed_d     = '0;
                end
            end
            S_READ: begin
                lfsr_d = f_lfsr_next(lfsr_q);
                if (w_flush) begin
                    state_d = S_DRAIN;
                end else begin
                    w_issue = 1'b1;
                    if (addr_q == C_LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // The last outstanding compare retires on this same edge.
                if (w_flush || ((pipe_vld_q & C_UP_MASK) == '0)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pipe_vld_d = w_flush ? '0 : ((pipe_vld_q << 1) | READ_LATENCY'(w_issue));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            lfsr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fea_q      <= '0;
            fed_q      <= '0;
            pipe_vld_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lfsr_q     <= lfsr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fea_q      <= fea_d;
            fed_q      <= fed_d;
            pipe_vld_q <= pipe_vld_d;
        end
    end

    // Payload shifts freely; only the valid bits carry meaning.
    always_ff @(posedge clk) begin
        pipe_addr_q[0] <= addr_q;
        pipe_exp_q[0]  <= lfsr_q[DATA_WIDTH-1:0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_addr_q[i] <= pipe_addr_q[i-1];
            pipe_exp_q[i]  <= pipe_exp_q[i-1];
        end
    end

    assign mem_we         = 1'b0;
    assign mem_addr       = addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_cnt_q;
    assign first_err_addr = fea_q;
    assign first_err_data = fed_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_readback_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ram_readback_checker
// Description : Randomised scoreboard bench with a RAM model and a
//               pattern-level reference model of the expected sweep result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_readback_checker;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int RL    = 1;
    localparam int DEPTH = 1 << AW;

`ifdef RAM_CHK_STOP_ON_FIRST_ERR_EN
    localparam bit STOP_MODE = 1'b1;
`else
    localparam bit STOP_MODE = 1'b0;
`endif

    typedef struct {
        int  pass;
        int  err;
        int  fea;
        int  fed;
        int  lat_lo;
        int  lat_hi;
        time t_acc;
    } exp_t;

    logic          clk, rst, start;
    logic [15:0]   seed;
    logic          mem_we, busy, done, pass;
    logic [AW-1:0] mem_addr, first_err_addr;
    logic [DW-1:0] mem_q, first_err_data;
    logic [AW:0]   err_count;

    logic [DW-1:0] ram    [DEPTH];
    logic [DW-1:0] q_pipe [RL];

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   we_seen = 1'b0;

    ram_readback_checker #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .seed          (seed),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_q         (mem_q),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: data appears RL cycles after the address is sampled.
    always @(posedge clk) begin
        q_pipe[0] <= ram[mem_addr];
        for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign mem_q = q_pipe[RL-1];

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic fill(input logic [15:0] s);
        logic [15:0] l;
        l = (s == 16'h0000) ? 16'hACE1 : s;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = l[DW-1:0];
            l = lfsr_step(l);
        end
    endtask

    function automatic exp_t model(input logic [15:0] s);
        exp_t        e;
        logic [15:0] l;
        e.err = 0; e.fea = 0; e.fed = 0; e.t_acc = 0;
        l = (s == 16'h0000) ? 16'hACE1 : s;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram[i] != l[DW-1:0]) begin
                if (e.err == 0) begin
                    e.fea = i;
                    e.fed = int'(ram[i]);
                end
                e.err++;
            end
            l = lfsr_step(l);
        end
        e.pass   = (e.err == 0) ? 1 : 0;
        e.lat_lo = DEPTH + RL + 1;
        e.lat_hi = DEPTH + RL + 1;
        if (STOP_MODE && e.err > 0) begin
            e.err    = 1;
            e.lat_lo = (e.fea + 1 + RL) + 1;
            e.lat_hi = (e.fea + 1 + RL) + RL + 1;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Monitor: retire one scoreboard entry on each rising edge of done.
    initial begin
        exp_t e;
        int   n;
        bit   done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_we) we_seen = 1'b1;
            if (!rst && done && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    n = int'(($time - e.t_acc - 5) / 10) + 1;
                    chk("pass", int'(pass), e.pass);
                    chk("err_count", int'(err_count), e.err);
                    chk("first_err_addr", int'(first_err_addr), e.fea);
                    chk("first_err_data", int'(first_err_data), e.fed);
                    chk("busy_at_done", int'(busy), 0);
                    chk_rng("done_cycle", n, e.lat_lo, e.lat_hi);
                end
            end
            done_prev = done;
        end
    end

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout: done still 0 after %0d cycles", budget);
        end
    endtask

    task automatic issue(input logic [15:0] s);
        exp_t e;
        e = model(s);
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        e.t_acc = $time;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sweep(input logic [15:0] s);
        @(negedge clk);
        issue(s);
        wait_done(200);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_we"}, int'(mem_we), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_first_err_addr"}, int'(first_err_addr), 0);
        chk({tag, "_first_err_data"}, int'(first_err_data), 0);
    endtask

    initial begin
        logic [15:0] s;
        int          nc;
        int          a;
        rst   = 1'b1;
        start = 1'b0;
        seed  = 16'h0000;
        for (int i = 0; i < RL; i++) q_pipe[i] = '0;
        fill(16'h0001);
        // start asserted alongside reset must be ignored
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        chk_reset_vals("reset");

        // Good RAM, seed 1
        run_sweep(16'h0001);

        // Zero seed maps to ACE1; the same fill against seed 1 must fail
        fill(16'h0000);
        run_sweep(16'h0000);
        run_sweep(16'h0001);

        // Single corrupted word
        fill(16'h0001);
        ram[37] = ram[37] ^ 8'h08;
        run_sweep(16'h0001);

        // Two corruptions
        fill(16'h0001);
        ram[5]  = ram[5] ^ 8'h81;
        ram[60] = ram[60] ^ 8'h10;
        run_sweep(16'h0001);

        // Reset in cycle 20 of a sweep aborts it with no result
        fill(16'h0001);
        @(negedge clk);
        issue(16'h0001);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("abort");
        run_sweep(16'h0001);

        // Starts while busy and in the done-rise cycle are ignored
        fill(16'h1234);
        ram[0] = ram[0] ^ 8'h01;
        @(negedge clk);
        issue(16'h1234);
        repeat (29) @(negedge clk);
        seed  = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed  = 16'h1234;
        wait_done(200);
        start = 1'b1;
        @(negedge clk);
        chk("ign_busy", int'(busy), 0);
        chk("ign_done", int'(done), 1);
        issue(16'h1234);
        chk("acc_busy", int'(busy), 1);
        chk("acc_done", int'(done), 0);
        wait_done(200);

        // Randomised fills, corruptions and check seeds
        for (int t = 0; t < 10; t++) begin
            s = 16'($urandom);
            fill(s);
            nc = $urandom_range(3);
            for (int j = 0; j < nc; j++) begin
                a = $urandom_range(DEPTH - 1);
                ram[a] = ram[a] ^ DW'(1 << $urandom_range(DW - 1));
            end
            if ($urandom_range(4) == 0) s = 16'($urandom);
            repeat ($urandom_range(3)) @(negedge clk);
            run_sweep(s);
        end

        repeat (3) @(negedge clk);
        chk("mem_we_ever_high", int'(we_seen), 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_readback_checker.md
Name: ram_readback_checker

Overview:
- Synthesizable read-side initiator for the synchronous single-port RAM (`we`, `addr`, `data`, `q`) used by the post-route netlist benches.
- Sweeps every address with `we` held low and regenerates the pseudo-random fill pattern from a seed.
- Compares each returned word against the pattern; reports pass/fail, mismatch count and the first failing address and data.
- Sits beside the RAM as an on-chip self-check, so netlist runs need no golden dump.

Parameters:
- DATA_WIDTH, 8, RAM word width (1..16).
- ADDR_WIDTH, 6, RAM address width; DEPTH = 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from address sampled to valid `mem_q` (1..3).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- seed  in  16  pattern seed, latched on accepted start.
- mem_we  out  1  RAM write enable, constant 0.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_q  in  DATA_WIDTH  RAM read data.
- busy  out  1  high from accepted start until done.
- done  out  1  level, high after sweep; cleared by next accepted start or rst.
- pass  out  1  valid when done; 1 = zero mismatches.
- err_count  out  ADDR_WIDTH+1  number of mismatching words.
- first_err_addr  out  ADDR_WIDTH  address of first mismatch (0 if none).
- first_err_data  out  DATA_WIDTH  mem_q at first mismatch (0 if none).

Behaviour:
- Reset values: mem_we=0, mem_addr=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, first_err_data=0. FSM goes to IDLE and compare pipeline valid bits clear.
- Reset wins over start in the same cycle. Reset mid-sweep aborts immediately and leaves no partial result.
- Pattern: 16-bit Fibonacci LFSR, next = {l[14:0], l[15]^l[13]^l[12]^l[10]}.
  - Seed 16'h0000 is replaced by 16'hACE1.
  - Expected word for address i = low DATA_WIDTH bits of the LFSR after i steps; step 0 = seed.
- FSM states IDLE, READ, DRAIN, DONE.
  - IDLE: on start, latch seed, clear counters/result, set busy=1, done=0; go to READ.
  - READ: cycle k (k=1..DEPTH after the accept edge) drives mem_addr=k-1. The LFSR advances each cycle. Each issued address and its expected word enter a READ_LATENCY-deep pipeline. After address DEPTH-1 go to DRAIN; mem_addr holds DEPTH-1.
  - DRAIN: wait until the pipeline empties, then go to DONE.
  - DONE: busy=0, done=1, pass=(err_count==0). Go to IDLE in the same cycle. done stays high until the next accepted start.
- Compare: in cycle k+READ_LATENCY, mem_q is compared with the expected word for address k-1.
  - On mismatch, err_count increments.
  - If this is the first mismatch, first_err_addr and first_err_data capture address and mem_q.
- Latency: done rises in cycle DEPTH+READ_LATENCY+1 after the accept edge.
- start while busy is ignored. start in the same cycle done rises is ignored; start one cycle later is accepted.
- err_count cannot overflow: the maximum is DEPTH, which fits in ADDR_WIDTH+1 bits.
- mem_addr does not wrap: the sweep ends at DEPTH-1.

Optional Feature:
- Macro RAM_CHK_STOP_ON_FIRST_ERR_EN.
- Defined: the first mismatch ends the sweep.
  - FSM goes to DRAIN; no new addresses are issued.
  - In-flight compares are discarded; err_count=1.
  - done rises READ_LATENCY+1 cycles after the mismatch compare cycle or earlier, never later.
- Undefined: the full sweep always runs and every mismatch is counted.

Test Plan:
- Good RAM: bench fills DEPTH=64 words with the LFSR pattern from seed 16'h0001 (addr0=8'h01, addr1=8'h02), start with seed 16'h0001 -> done at cycle 66 (READ_LATENCY=1), pass=1, err_count=0, first_err_addr=0, mem_we never 1.
- Seed 16'h0000 fill vs pattern from 16'hACE1 -> pass=1. The same fill checked with seed 16'h0001 -> pass=0, err_count>0.
- Single corrupted word: flip bit 3 at address 6'd37 -> pass=0, err_count=1, first_err_addr=37, first_err_data = expected^8'h08.
- Two corruptions at addresses 5 and 60 -> err_count=2, first_err_addr=5. With RAM_CHK_STOP_ON_FIRST_ERR_EN -> err_count=1, done well before cycle 66.
- rst pulsed at cycle 20 of a sweep, then a new start -> all outputs at reset values after the rst pulse; second sweep completes with pass=1.
- start pulsed while busy and in the cycle done rises -> ignored, no restart. start one cycle later -> accepted, done drops, busy rises.
